musk_mem_responder: RTL and testbench
=====================================

# musk_mem_responder

Memory-side responder for the MUSKBUS request/response bus. It accepts line-granular read and write requests issued by a bus initiator as `req_t` beats, keeps a local 64-bit-wide backing store, and returns read lines as `resp_t` beats. It sits at the far end of the bus from the cache/fetch initiators and acts as the main-memory model for system simulation and the template for the real DRAM bridge.

## Interface
- `DEPTH`, 4096: backing-store depth in 64-bit words; power of two.
- `LATENCY`, 4: idle cycles between read-address acceptance and the first response beat; 0 is legal.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `bus_req`  in  `req_t` (79)  fields `bid` (ignored), `reqcyc`, `reqtag`, `req`.
- `reqack`  out  1  beat accepted this cycle.
- `bus_resp`  out  `resp_t` (65)  fields `respcyc`, `resp`.
- `respack`  in  1  initiator consumed the current response beat.
- `bad_tag`  out  1  sticky; set on any accepted beat carrying an unsupported or out-of-place tag.

## Operation
- Beat transfer: request beat moves when `reqcyc && reqack`; response beat moves when `respcyc && respack`.
- `reqack` is combinational: `reqcyc` and state is IDLE or WR_DATA. It is 0 in RD_WAIT and RD_SEND, so the initiator must hold its beat.
- Line is `LINE_BEATS` = 8 words (64 B). Address beat `req` is a byte address; bits [5:0] are ignored. Word index is `(addr[63:3] & ~7) + beat` mod `DEPTH`, so high address bits wrap.
- States:
  - IDLE
    - accepted `READ_MEM_TAG` beat: latch line base, then go to RD_WAIT (or RD_SEND when `LATENCY`=0).
    - accepted `WRITE_MEM_TAG` beat: latch base, go to WR_DATA with beat count 0.
    - any other accepted tag: set `bad_tag`, stay in IDLE, no response.
  - WR_DATA
    - each accepted beat writes `req` to word base+count.
    - tag other than `WRITE_MEM_TAG`: still written as data, `bad_tag` set.
    - after the 8th beat, return to IDLE.
  - RD_WAIT: count `LATENCY` cycles, then RD_SEND.
  - RD_SEND
    - present words base+0..7 in ascending order.
    - each beat holds stable until `respack`; next beat appears the following cycle.
    - after the 8th acked beat, return to IDLE.
- Read-after-write to the same line returns the new data.
- No write response.

## Timing
- Reset values: `reqack` 0 (reset dominates), `bus_resp` all zero, `bad_tag` 0, state IDLE, counters 0. Backing-store contents are not reset.
- Reset mid-burst aborts it:
  - `respcyc` drops the cycle after reset is sampled.
  - A partially written line keeps the beats already written.
- Read address accepted in cycle T: first `respcyc` in cycle T+1+`LATENCY`.
  - With `respack` held high, beats occupy T+1+L .. T+8+L.
  - The earliest next `reqack` is T+9+L.
- `respack` low stalls the current beat indefinitely, with no loss or reordering.
- `respack` while `respcyc`=0 is ignored.
- Write: address in cycle T; data beats accepted in any later cycles with `reqcyc`; IDLE again the cycle after the 8th data beat.
- Back-to-back operations: a new request is accepted in the first IDLE cycle; no bubble is required after a write.
- `resp` holds its last value while `respcyc`=0; it is not required to be zero.

## Structure
- Add to package `MUSKBUS`:
  - `LINE_BEATS` = 8 and `LINE_BYTES` = 64.
  - Fix the missing `;` separators in the parameter list so `READ_MEM_TAG`/`WRITE_MEM_TAG` are legal 13-bit parameters.
  - Document `reqack`/`respack` as the bus handshake signals.
- Sub-module `musk_bus_sram`: single-clock, `DEPTH`x64, one write port and one synchronous read port (1-cycle read latency).
  - The responder prefetches the next word during RD_WAIT and on each ack so that 1-beat/cycle streaming holds.
- FSM and counters live in `musk_mem_responder`.

## Test plan
- Reset, then write line 0x1000 with data 0x11..0x88, read 0x1000 with `LATENCY`=4, `respack` high → address accepted at T, beats 0x11..0x88 at T+5..T+12.
- Read 0x103F → same line as 0x1000 (low bits ignored); `LATENCY`=0 → first beat at T+1.
- Random `respack` deasserts during a read → each beat stable while unacked, exactly 8 transfers, order preserved; `reqack`=0 throughout.
- Address beat with tag {READ, PORT, 8'b0} → accepted, `bad_tag`=1 next cycle and sticky, no `respcyc`; next valid read still served.
- `DEPTH`=4096, write to byte address 0x8000 (word 4096) → data appears on read of 0x0.
- Assert `reset` after the 3rd read beat / after the 4th write beat → `respcyc`=0 next cycle, state IDLE, `reqack` resumes; readback shows beats 0–3 new, 4–7 old.

Source files
------------

// File: rtl/musk_mem_responder_pkg.sv
// MUSKBUS package: request/response beat layouts, tag encodings and line
// geometry shared by bus initiators and the memory responder.
//
// Handshake: a request beat transfers when reqcyc && reqack (reqack driven
// by the target); a response beat transfers when respcyc && respack
// (respack driven by the initiator).
package MUSKBUS;

  // Tag layout: {cmd[2:0], dest[1:0], sub[7:0]}
  localparam logic [2:0] TAG_CMD_READ  = 3'd1;
  localparam logic [2:0] TAG_CMD_WRITE = 3'd2;
  localparam logic [1:0] TAG_DEST_MEM  = 2'd0;
  localparam logic [1:0] TAG_DEST_PORT = 2'd1;

  parameter logic [12:0] READ_MEM_TAG  = {TAG_CMD_READ,  TAG_DEST_MEM, 8'h00};
  parameter logic [12:0] WRITE_MEM_TAG = {TAG_CMD_WRITE, TAG_DEST_MEM, 8'h00};

  // A line is eight 64-bit words.
  localparam int LINE_BEATS = 8;
  localparam int LINE_BYTES = 64;

  typedef struct packed {
    logic        bid;
    logic        reqcyc;
    logic [12:0] reqtag;
    logic [63:0] req;
  } req_t;

  typedef struct packed {
    logic        respcyc;
    logic [63:0] resp;
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_SEND = 2'd3
  } resp_state_t;

endpackage

// File: rtl/musk_mem_responder_sram.sv
// Single-clock DEPTH x 64 store: one write port, one synchronous read port
// whose output register only updates when re is high.
module musk_bus_sram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem_r [DEPTH];
  logic [63:0] rdata_r;

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, held when re is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= 64'd0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/musk_mem_responder.sv
// MUSKBUS memory responder: accepts line read/write requests, keeps a local
// backing store and streams read lines back one word per cycle.
module musk_mem_responder
  import MUSKBUS::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  req_t  bus_req,
  output logic  reqack,
  output resp_t bus_resp,
  input  logic  respack,
  output logic  bad_tag
);

  localparam int AW = $clog2(DEPTH);

  resp_state_t   state_r;
  logic [AW-4:0] base_hi_r;
  logic [2:0]    beat_r;
  logic [31:0]   wait_r;
  logic          respcyc_r;
  logic          bad_tag_r;

  logic          accept_s;
  logic          is_read_s;
  logic          is_write_s;
  logic [AW-4:0] addr_hi_s;
  logic          re_s;
  logic [AW-1:0] raddr_s;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [63:0]   rdata_s;
  logic          last_beat_s;
  logic          unused_s;

  assign is_read_s   = (bus_req.reqtag == READ_MEM_TAG);
  assign is_write_s  = (bus_req.reqtag == WRITE_MEM_TAG);
  // Line base in words: byte address bits [5:0] dropped, upper bits wrap.
  assign addr_hi_s   = bus_req.req[AW+2:6];
  assign last_beat_s = (beat_r == 3'(LINE_BEATS - 1));
  assign unused_s    = bus_req.bid;

  // Request acceptance: only IDLE and WR_DATA take beats; reset blocks it.
  always_comb begin
    accept_s = 1'b0;
    if (reset) begin
      accept_s = 1'b0;
    end else if (bus_req.reqcyc && (state_r == ST_IDLE || state_r == ST_WR_DATA)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  assign reqack = accept_s;

  // Read-port steering: word 0 is fetched at address accept and held through
  // RD_WAIT; during RD_SEND the next word is fetched on each ack.
  always_comb begin
    re_s    = 1'b0;
    raddr_s = {base_hi_r, beat_r};
    case (state_r)
      ST_IDLE: begin
        re_s    = accept_s && is_read_s;
        raddr_s = {addr_hi_s, 3'b000};
      end
      ST_RD_WAIT: begin
        re_s    = 1'b1;
        raddr_s = {base_hi_r, 3'b000};
      end
      ST_RD_SEND: begin
        re_s = 1'b1;
        if (respcyc_r && respack) begin
          raddr_s = {base_hi_r, beat_r + 3'd1};
        end else begin
          raddr_s = {base_hi_r, beat_r};
        end
      end
      default: begin
        re_s    = 1'b0;
        raddr_s = {base_hi_r, beat_r};
      end
    endcase
  end

  assign we_s    = accept_s && (state_r == ST_WR_DATA);
  assign waddr_s = {base_hi_r, beat_r};

  musk_bus_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (bus_req.req),
    .re    (re_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Main FSM: line base, beat/latency counters, response valid, sticky bad_tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      base_hi_r <= '0;
      beat_r    <= 3'd0;
      wait_r    <= 32'd0;
      respcyc_r <= 1'b0;
      bad_tag_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (is_read_s) begin
              base_hi_r <= addr_hi_s;
              beat_r    <= 3'd0;
              wait_r    <= 32'd0;
              if (LATENCY == 0) begin
                state_r   <= ST_RD_SEND;
                respcyc_r <= 1'b1;
              end else begin
                state_r <= ST_RD_WAIT;
              end
            end else if (is_write_s) begin
              base_hi_r <= addr_hi_s;
              beat_r    <= 3'd0;
              state_r   <= ST_WR_DATA;
            end else begin
              bad_tag_r <= 1'b1;
            end
          end
        end
        ST_WR_DATA: begin
          if (accept_s) begin
            if (!is_write_s) begin
              bad_tag_r <= 1'b1;
            end
            if (last_beat_s) begin
              beat_r  <= 3'd0;
              state_r <= ST_IDLE;
            end else begin
              beat_r <= beat_r + 3'd1;
            end
          end
        end
        ST_RD_WAIT: begin
          if (wait_r == 32'(LATENCY - 1)) begin
            wait_r    <= 32'd0;
            state_r   <= ST_RD_SEND;
            respcyc_r <= 1'b1;
          end else begin
            wait_r <= wait_r + 32'd1;
          end
        end
        ST_RD_SEND: begin
          if (respcyc_r && respack) begin
            if (last_beat_s) begin
              beat_r    <= 3'd0;
              respcyc_r <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              beat_r <= beat_r + 3'd1;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          respcyc_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus_resp = {respcyc_r, rdata_s};
  assign bad_tag  = bad_tag_r;

endmodule

// File: tb/tb_musk_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 4 and 0) driven by line-level
// tasks; a behavioural word-array model predicts read data and beat timing.
module tb_musk_mem_responder;
  import MUSKBUS::*;

  localparam int DEPTH = 4096;

  typedef struct {
    logic [63:0] data;
    int          first_cyc;
  } sb_t;

  logic  clk = 1'b0;
  logic  reset;
  req_t  bus_req  [2];
  logic  reqack   [2];
  resp_t bus_resp [2];
  logic  respack  [2];
  logic  bad_tag  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sb_t         sbq   [2][$];
  logic [63:0] model [2][DEPTH];
  bit          rnd_ack [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  musk_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_dut0 (
    .clk(clk), .reset(reset), .bus_req(bus_req[0]), .reqack(reqack[0]),
    .bus_resp(bus_resp[0]), .respack(respack[0]), .bad_tag(bad_tag[0]));

  musk_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(reset), .bus_req(bus_req[1]), .reqack(reqack[1]),
    .bus_resp(bus_resp[1]), .respack(respack[1]), .bad_tag(bad_tag[1]));

  function automatic int lat(int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic int widx(logic [63:0] addr, int k);
    logic [63:0] w;
    w = (((addr >> 3) & ~64'd7) + 64'(k)) % 64'(DEPTH);
    return int'(w);
  endfunction

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every presented beat is compared with the queue head; popped on ack.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (bus_resp[d].respcyc) begin
        chk($sformatf("reqack_low_during_read%0d", d), 80'(reqack[d]), 80'd0);
        if (sbq[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat%0d actual=resp %h required=no beat", d, bus_resp[d].resp);
        end else begin
          chk($sformatf("rd_data%0d", d), 80'(bus_resp[d].resp), 80'(sbq[d][0].data));
          if (sbq[d][0].first_cyc >= 0) begin
            chk($sformatf("first_beat_cycle%0d", d), 80'(cyc), 80'(sbq[d][0].first_cyc));
            sbq[d][0].first_cyc = -1;
          end
          if (respack[d]) void'(sbq[d].pop_front());
        end
      end
    end
  end

  // Response-side initiator: respack held high or randomised per cycle.
  initial begin
    respack[0] = 1'b1;
    respack[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        respack[d] = rnd_ack[d] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_beat(int d, logic [12:0] tag, logic [63:0] data, output int t);
    bus_req[d].bid    = 1'b0;
    bus_req[d].reqcyc = 1'b1;
    bus_req[d].reqtag = tag;
    bus_req[d].req    = data;
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (reqack[d]) begin
        t = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus_req[d].reqcyc = 1'b0;
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout%0d actual=no reqack required=reqack", d);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
  endtask

  task automatic wr_line(int d, logic [63:0] addr, input logic [63:0] data [8], int abort_after);
    int t;
    send_beat(d, WRITE_MEM_TAG, addr, t);
    for (int k = 0; k < 8; k++) begin
      if (k == abort_after) begin
        do_reset();
        break;
      end
      send_beat(d, WRITE_MEM_TAG, data[k], t);
      if (t >= 0) model[d][widx(addr, k)] = data[k];
    end
  endtask

  task automatic rd_issue(int d, logic [63:0] addr, logic [12:0] tag, output int t);
    send_beat(d, tag, addr, t);
    if (t >= 0) begin
      for (int k = 0; k < 8; k++) begin
        sb_t e;
        e.data      = model[d][widx(addr, k)];
        e.first_cyc = (k == 0) ? t + 1 + lat(d) : -1;
        sbq[d].push_back(e);
      end
    end
  endtask

  task automatic drain(int d);
    for (int i = 0; i < 600 && sbq[d].size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sbq[d].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout%0d actual=%0d pending required=0", d, sbq[d].size());
    end
  endtask

  task automatic rand_line(output logic [63:0] l [8]);
    for (int k = 0; k < 8; k++) l[k] = {$urandom, $urandom};
  endtask

  initial begin
    logic [63:0] line [8];
    logic [63:0] line2 [8];
    int t1, t2;

    for (int d = 0; d < 2; d++) begin
      bus_req[d] = '0;
      rnd_ack[d] = 1'b0;
    end
    // Reset dominates: a pending beat must not be acked while reset is high.
    reset = 1'b1;
    bus_req[0].reqcyc = 1'b1;
    bus_req[0].reqtag = WRITE_MEM_TAG;
    bus_req[1].reqcyc = 1'b1;
    bus_req[1].reqtag = READ_MEM_TAG;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_reqack%0d", d), 80'(reqack[d]), 80'd0);
      chk($sformatf("reset_bus_resp%0d", d), 80'(bus_resp[d]), 80'd0);
      chk($sformatf("reset_bad_tag%0d", d), 80'(bad_tag[d]), 80'd0);
    end
    @(posedge clk);
    #1;
    bus_req[0].reqcyc = 1'b0;
    bus_req[1].reqcyc = 1'b0;
    reset = 1'b0;

    // Directed line 0x1000 = 0x11..0x88 in both stores.
    for (int k = 0; k < 8; k++) line[k] = 64'(8'h11 * (k + 1));
    wr_line(0, 64'h1000, line, 8);
    wr_line(1, 64'h1000, line, 8);
    chk("model_word0", 80'(model[0][512]), 80'h11);

    // Back-to-back reads: second held until earliest accept T+9+L.
    rd_issue(0, 64'h1000, READ_MEM_TAG, t1);
    rd_issue(0, 64'h1000, READ_MEM_TAG, t2);
    chk("next_accept_l4", 80'(t2), 80'(t1 + 13));
    drain(0);

    // Low six address bits ignored; zero latency.
    rd_issue(1, 64'h103F, READ_MEM_TAG, t1);
    rd_issue(1, 64'h1008, READ_MEM_TAG, t2);
    chk("next_accept_l0", 80'(t2), 80'(t1 + 9));
    drain(1);

    // Randomised lines and randomised respack stalls.
    rnd_ack[0] = 1'b1;
    rnd_ack[1] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      a = {52'd0, a[11:0]} | 64'h2000;
      for (int d = 0; d < 2; d++) begin
        rand_line(line);
        wr_line(d, a, line, 8);
        rd_issue(d, a | 64'(r), READ_MEM_TAG, t1);
        drain(d);
      end
    end
    rnd_ack[0] = 1'b0;
    rnd_ack[1] = 1'b0;

    // Unsupported tag: accepted, flagged, no response; next read served.
    send_beat(0, {TAG_CMD_READ, TAG_DEST_PORT, 8'h00}, 64'h1000, t1);
    @(negedge clk);
    chk("bad_tag_set", 80'(bad_tag[0]), 80'd1);
    repeat (12) @(posedge clk);
    #1;
    rd_issue(0, 64'h1000, READ_MEM_TAG, t1);
    drain(0);
    @(negedge clk);
    chk("bad_tag_sticky", 80'(bad_tag[0]), 80'd1);
    chk("bad_tag_other_dut", 80'(bad_tag[1]), 80'd0);
    @(posedge clk);
    #1;

    // Address wrap: byte 0x8000 is word 4096, which aliases word 0.
    rand_line(line);
    wr_line(0, 64'h8000, line, 8);
    rd_issue(0, 64'h0, READ_MEM_TAG, t1);
    drain(0);
    chk("wrap_model_alias", 80'(model[0][3]), 80'(line[3]));

    // Reset after the third read beat.
    rd_issue(0, 64'h1000, READ_MEM_TAG, t1);
    for (int i = 0; i < 100 && sbq[0].size() > 5; i++) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    @(negedge clk);
    chk("abort_respcyc", 80'(bus_resp[0].respcyc), 80'd0);
    chk("abort_bad_tag_cleared", 80'(bad_tag[0]), 80'd0);
    @(posedge clk);
    #1;
    rd_issue(0, 64'h1000, READ_MEM_TAG, t1);
    drain(0);

    // Reset after the fourth write beat: beats 0-3 new, 4-7 old.
    rand_line(line);
    wr_line(0, 64'h3000, line, 8);
    rand_line(line2);
    wr_line(0, 64'h3000, line2, 4);
    chk("partial_new_model", 80'(model[0][widx(64'h3000, 3)]), 80'(line2[3]));
    chk("partial_old_model", 80'(model[0][widx(64'h3000, 4)]), 80'(line[4]));
    rd_issue(0, 64'h3000, READ_MEM_TAG, t1);
    drain(0);

    repeat (20) @(posedge clk);
    #1;
    chk("sb_empty0", 80'(sbq[0].size()), 80'd0);
    chk("sb_empty1", 80'(sbq[1].size()), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a hung handshake.
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
